audio_pwm_mixer: RTL and testbench

Mixes the unsigned PCM sample outputs of up to NUM_CHANNELS sound players (8-bit, 0 when idle) into a single saturated level and drives a 1-bit PWM audio pin. Sits directly downstream of the per-effect players and directly upstream of the board audio output. The mixed level is latched once per PWM period, so the carrier stays glitch-free while player samples change at any time.

---
 rtl/audio_pwm_mixer.sv | 135 +++++++++++++
 tb/tb_audio_pwm_mixer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_mixer.sv
// audio_pwm_mixer
// Mixes NUM_CHANNELS unsigned PCM samples into one saturated level and plays it
// on a 1-bit PWM pin. The mix is latched only at PWM period boundaries, so each
// period plays one duty from start to end while the players change samples freely.
//
// Ports:
//   i_clk            system clock (single domain)
//   i_rst            synchronous active-high reset
//   i_in             packed samples, channel i = i_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   i_mute           per-channel mute, 1 = channel contributes 0
//   i_vol_shift      per-channel right shift 0..3, channel i = i_vol_shift[2i +: 2]
//   i_enable         master enable, 0 forces o_pwm_out low (counters keep running)
//   o_pwm_out        registered PWM audio output
//   o_level          duty currently being played
//   o_period_strobe  one-cycle pulse in the first cycle of each PWM period
module audio_pwm_mixer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 8,
  parameter int PWM_DIV      = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_in,
  input  logic [NUM_CHANNELS-1:0]              i_mute,
  input  logic [2*NUM_CHANNELS-1:0]            i_vol_shift,
  input  logic                                 i_enable,
  output logic                                 o_pwm_out,
  output logic [SAMPLE_WIDTH-1:0]              o_level,
  output logic                                 o_period_strobe
);

  // Enough headroom that the sum of all channels at full scale cannot wrap.
  localparam int CH_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SUM_W   = SAMPLE_WIDTH + CH_BITS;
  localparam int PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  localparam logic [SUM_W-1:0]        SAT_MAX  = {{CH_BITS{1'b0}}, {SAMPLE_WIDTH{1'b1}}};
  localparam logic [PRE_W-1:0]        PRE_LAST = PRE_W'(PWM_DIV - 1);
  localparam logic [PRE_W-1:0]        PRE_ONE  = PRE_W'(1);
  localparam logic [SAMPLE_WIDTH-1:0] CNT_LAST = {SAMPLE_WIDTH{1'b1}};
  localparam logic [SAMPLE_WIDTH-1:0] CNT_ONE  = SAMPLE_WIDTH'(1);

  logic [SAMPLE_WIDTH-1:0] w_sample;
  logic [1:0]              w_shift;
  logic [SAMPLE_WIDTH-1:0] w_contrib;
  logic [SUM_W-1:0]        w_sum;
  logic [SAMPLE_WIDTH-1:0] w_sat;
  logic                    w_tick;
  logic                    w_boundary;

  logic [PRE_W-1:0]        r_pre;
  logic [SAMPLE_WIDTH-1:0] r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_sum_q;
  logic [SAMPLE_WIDTH-1:0] r_duty;
  logic                    r_pwm;
  logic                    r_strobe;

  // Attenuate/mute each channel and accumulate into the widened sum.
  always_comb begin
    w_sum     = '0;
    w_sample  = '0;
    w_shift   = 2'd0;
    w_contrib = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_sample = i_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      w_shift  = i_vol_shift[2*i +: 2];
      if (i_mute[i]) begin
        w_contrib = '0;
      end else begin
        w_contrib = w_sample >> w_shift;
      end
      w_sum = w_sum + {{CH_BITS{1'b0}}, w_contrib};
    end
  end

  // Clip the sum to full scale rather than letting it wrap.
  always_comb begin
    if (w_sum > SAT_MAX) begin
      w_sat = {SAMPLE_WIDTH{1'b1}};
    end else begin
      w_sat = w_sum[SAMPLE_WIDTH-1:0];
    end
  end

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_boundary = w_tick && (r_cnt == CNT_LAST);

  // Prescaler producing one step tick every PWM_DIV clocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_ONE;
    end
  end

  // Step counter, period strobe and duty latch; duty only changes on the boundary.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_duty   <= '0;
      r_strobe <= 1'b0;
    end else if (w_boundary) begin
      r_cnt    <= '0;
      r_duty   <= r_sum_q;
      r_strobe <= 1'b1;
    end else if (w_tick) begin
      r_cnt    <= r_cnt + CNT_ONE;
      r_duty   <= r_duty;
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= r_cnt;
      r_duty   <= r_duty;
      r_strobe <= 1'b0;
    end
  end

  // Registered mix and PWM compare; pwm lags the counter by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum_q <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_sum_q <= w_sat;
      r_pwm   <= i_enable && (r_cnt < r_duty);
    end
  end

  assign o_pwm_out       = r_pwm;
  assign o_level         = r_duty;
  assign o_period_strobe = r_strobe;

endmodule

// File: tb/tb_audio_pwm_mixer.sv
// Self-checking bench for audio_pwm_mixer: two instances (PWM_DIV = 1 and 4)
// share the stimulus and are compared every cycle against a cycle-count model.
module tb_audio_pwm_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_s = 32'h0;
  logic [3:0]  mute = 4'h0;
  logic [7:0]  vol  = 8'h0;
  logic        en   = 1'b0;

  logic       pwm1, stb1, pwm4, stb4;
  logic [7:0] lvl1, lvl4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_pwm_mixer #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(8), .PWM_DIV(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_in(in_s), .i_mute(mute), .i_vol_shift(vol),
    .i_enable(en), .o_pwm_out(pwm1), .o_level(lvl1), .o_period_strobe(stb1)
  );

  audio_pwm_mixer #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(8), .PWM_DIV(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_in(in_s), .i_mute(mute), .i_vol_shift(vol),
    .i_enable(en), .o_pwm_out(pwm4), .o_level(lvl4), .o_period_strobe(stb4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Saturated mix of the current inputs, straight from the contribution rules.
  function automatic int mix(input logic [31:0] v, input logic [3:0] m, input logic [7:0] s);
    int sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (!m[i]) sum += int'(v[i*8 +: 8]) >> s[2*i +: 2];
    end
    return (sum > 255) ? 255 : sum;
  endfunction

  // Model: k = clock edges since reset; step = (k/div) mod 256; a new period
  // starts at every k that is a multiple of 256*div and plays the mix that was
  // registered one edge earlier.
  int divs [2] = '{1, 4};
  int mk   [2];
  int mduty[2];
  int mpwm [2];
  int mstb [2];
  int mprev[2];

  initial begin
    logic s_rst, s_en;
    int   s_mix;
    for (int d = 0; d < 2; d++) begin
      mk[d] = 0; mduty[d] = 0; mpwm[d] = 0; mstb[d] = 0; mprev[d] = 0;
    end
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_en  = en;
      s_mix = mix(in_s, mute, vol);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (s_rst) begin
          mk[d] = 0; mduty[d] = 0; mpwm[d] = 0; mstb[d] = 0; mprev[d] = 0;
        end else begin
          mpwm[d] = (s_en && (((mk[d] / divs[d]) % 256) < mduty[d])) ? 1 : 0;
          mk[d]   = mk[d] + 1;
          if ((mk[d] % (256 * divs[d])) == 0) begin
            mduty[d] = mprev[d];
            mstb[d]  = 1;
          end else begin
            mstb[d]  = 0;
          end
          mprev[d] = s_mix;
        end
      end
      chk("model_pwm_div1",    {31'd0, pwm1}, mpwm[0]);
      chk("model_level_div1",  {24'd0, lvl1}, mduty[0]);
      chk("model_strobe_div1", {31'd0, stb1}, mstb[0]);
      chk("model_pwm_div4",    {31'd0, pwm4}, mpwm[1]);
      chk("model_level_div4",  {24'd0, lvl4}, mduty[1]);
      chk("model_strobe_div4", {31'd0, stb4}, mstb[1]);
    end
  end

  function automatic logic stb_of(input int w);
    return (w == 0) ? stb1 : stb4;
  endfunction

  function automatic logic pwm_of(input int w);
    return (w == 0) ? pwm1 : pwm4;
  endfunction

  // Advance to the next negedge on which the selected strobe is high.
  task automatic wait_stb(input int w, input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!stb_of(w) && waited < budget);
    chk("strobe_seen", {31'd0, stb_of(w)}, 32'd1);
  endtask

  // Count pwm highs over n cycles starting with the current one.
  task automatic count_high(input int w, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm_of(w)) hi++;
      @(negedge clk);
    end
  endtask

  // Advance until the div-1 step counter sits at the given value.
  task automatic wait_step(input int step);
    int guard = 0;
    while ((mk[0] % 256) != step && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk("step_reached", mk[0] % 256, step);
  endtask

  initial begin
    int w, hi;
    // Reset held 3 cycles with every channel at full scale.
    rst = 1'b1; en = 1'b1; in_s = 32'hFFFF_FFFF; mute = 4'h0; vol = 8'h0;
    repeat (3) @(negedge clk);
    chk("reset_pwm",    {31'd0, pwm1}, 32'd0);
    chk("reset_level",  {24'd0, lvl1}, 32'd0);
    chk("reset_strobe", {31'd0, stb1}, 32'd0);

    // Single channel 0x80; first period after reset must stay silent.
    in_s = 32'h0000_0080; mute = 4'b1110; rst = 1'b0;
    w = 0; hi = 0;
    do begin
      @(negedge clk);
      w++;
      if (pwm1) hi++;
    end while (!stb1 && w < 400);
    chk("first_strobe_delay", w, 256);
    chk("first_period_quiet", hi, 0);
    chk("single_level", {24'd0, lvl1}, 32'h80);
    count_high(0, 256, hi);
    chk("single_high_count", hi, 128);
    chk("single_strobe_cadence", {31'd0, stb1}, 32'd1);

    // Saturation, then drop to a small value mid-period.
    in_s = 32'hFFFF_FFFF; mute = 4'h0;
    wait_stb(0, 300, w);
    chk("sat_level", {24'd0, lvl1}, 32'hFF);
    count_high(0, 256, hi);
    chk("sat_high_count", hi, 255);
    repeat (50) @(negedge clk);
    in_s = 32'h0000_0010; mute = 4'b1110;
    repeat (100) @(negedge clk);
    chk("sat_level_held", {24'd0, lvl1}, 32'hFF);
    wait_stb(0, 300, w);
    chk("drop_level", {24'd0, lvl1}, 32'h10);

    // Attenuation and mute: 0xFF>>3 + 0x40>>1, ch2 muted, ch3 zero.
    in_s = 32'h00FF_40FF; mute = 4'b0100; vol = 8'b00_00_01_11;
    wait_stb(0, 300, w);
    chk("atten_level", {24'd0, lvl1}, 32'h3F);

    // Divider 4: period 1024 cycles, 0x40 steps high = 256 cycles.
    in_s = 32'h0000_0040; mute = 4'b1110; vol = 8'h0;
    wait_stb(1, 1100, w);
    wait_stb(1, 1100, w);
    chk("div4_period", w, 1024);
    chk("div4_level", {24'd0, lvl4}, 32'h40);
    count_high(1, 1024, hi);
    chk("div4_high_count", hi, 256);
    repeat (100) @(negedge clk);
    chk("div4_high_phase", {31'd0, pwm4}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("enable_off_pwm", {31'd0, pwm4}, 32'd0);
    wait_stb(1, 1100, w);
    chk("enable_off_cadence", w, 923);
    en = 1'b1;

    // Input change in the div-1 boundary cycle is not taken this period.
    wait_step(255);
    in_s = 32'h0000_00C0;
    wait_stb(0, 10, w);
    chk("late_change_old", {24'd0, lvl1}, 32'h40);
    wait_stb(0, 300, w);
    chk("late_change_new", {24'd0, lvl1}, 32'hC0);

    // Reset in the middle of a period.
    wait_step(100);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_pwm",    {31'd0, pwm1}, 32'd0);
    chk("midreset_level",  {24'd0, lvl1}, 32'd0);
    chk("midreset_strobe", {31'd0, stb1}, 32'd0);
    rst = 1'b0;
    wait_stb(0, 300, w);
    chk("midreset_restart", w, 256);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        in_s = $urandom();
        if ($urandom_range(0, 3) == 0) begin
          mute = 4'h0; vol = 8'h0;
        end else begin
          mute = 4'($urandom_range(0, 15));
          vol  = 8'($urandom_range(0, 255));
        end
      end
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 1499) == 0) rst = 1'b1;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
